// File: rtl/control.sv
// Main control decoder for the 16-bit datapath.
// Decodes the 4-bit opcode into registered datapath strobes (one clock latency).
// Optional build macro CONTROL_HALT_LATCH_EN: once HALT is registered, a sticky
// halted flag forces Halt=1 and every other output to 0 until reset.
module control (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] opcode,
   output logic       R15,
   output logic       ALUSrc,
   output logic       MemToReg,
   output logic       RegWrite,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       Branch,
   output logic [1:0] ALUOP,
   output logic       ByteOp,
   output logic [1:0] BrCond,
   output logic       Jump,
   output logic       Halt,
   output logic       Illegal
);

   typedef enum logic [3:0] {
      OP_HALT  = 4'b0000,
      OP_JMP   = 4'b0001,
      OP_BGT   = 4'b0100,
      OP_BLT   = 4'b0101,
      OP_BEQ   = 4'b0110,
      OP_LBU   = 4'b1000,
      OP_SB    = 4'b1001,
      OP_LW    = 4'b1010,
      OP_SW    = 4'b1011,
      OP_ADDI  = 4'b1100,
      OP_ORI   = 4'b1101,
      OP_ATYPE = 4'b1111
   } opcode_t;

   logic       d_r15;
   logic       d_alusrc;
   logic       d_memtoreg;
   logic       d_regwrite;
   logic       d_memread;
   logic       d_memwrite;
   logic       d_branch;
   logic [1:0] d_aluop;
   logic       d_byteop;
   logic [1:0] d_brcond;
   logic       d_jump;
   logic       d_halt;
   logic       d_illegal;

`ifdef CONTROL_HALT_LATCH_EN
   logic halted;

   // Sticky halted flag: set when HALT is registered, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset)
         halted <= 1'b0;
      else if (opcode == OP_HALT)
         halted <= 1'b1;
   end
`endif

   // Opcode decode into next-cycle strobe values
   always_comb begin
      d_r15      = 1'b0;
      d_alusrc   = 1'b0;
      d_memtoreg = 1'b0;
      d_regwrite = 1'b0;
      d_memread  = 1'b0;
      d_memwrite = 1'b0;
      d_branch   = 1'b0;
      d_aluop    = 2'b00;
      d_byteop   = 1'b0;
      d_brcond   = 2'b00;
      d_jump     = 1'b0;
      d_halt     = 1'b0;
      d_illegal  = 1'b0;
      case (opcode_t'(opcode))
         OP_ATYPE: begin
            d_regwrite = 1'b1;
            d_aluop    = 2'b10;
         end
         OP_LBU: begin
            d_alusrc   = 1'b1;
            d_memtoreg = 1'b1;
            d_regwrite = 1'b1;
            d_memread  = 1'b1;
            d_byteop   = 1'b1;
         end
         OP_SB: begin
            d_alusrc   = 1'b1;
            d_memwrite = 1'b1;
            d_byteop   = 1'b1;
         end
         OP_LW: begin
            d_alusrc   = 1'b1;
            d_memtoreg = 1'b1;
            d_regwrite = 1'b1;
            d_memread  = 1'b1;
         end
         OP_SW: begin
            d_alusrc   = 1'b1;
            d_memwrite = 1'b1;
         end
         OP_ADDI: begin
            d_alusrc   = 1'b1;
            d_regwrite = 1'b1;
         end
         OP_ORI: begin
            d_alusrc   = 1'b1;
            d_regwrite = 1'b1;
            d_aluop    = 2'b11;
         end
         OP_BLT: begin
            d_r15    = 1'b1;
            d_branch = 1'b1;
            d_aluop  = 2'b01;
            d_brcond = 2'b01;
         end
         OP_BGT: begin
            d_r15    = 1'b1;
            d_branch = 1'b1;
            d_aluop  = 2'b01;
            d_brcond = 2'b10;
         end
         OP_BEQ: begin
            d_r15    = 1'b1;
            d_branch = 1'b1;
            d_aluop  = 2'b01;
            d_brcond = 2'b00;
         end
         OP_JMP:  d_jump    = 1'b1;
         OP_HALT: d_halt    = 1'b1;
         default: d_illegal = 1'b1;
      endcase
`ifdef CONTROL_HALT_LATCH_EN
      if (halted) begin
         d_r15      = 1'b0;
         d_alusrc   = 1'b0;
         d_memtoreg = 1'b0;
         d_regwrite = 1'b0;
         d_memread  = 1'b0;
         d_memwrite = 1'b0;
         d_branch   = 1'b0;
         d_aluop    = 2'b00;
         d_byteop   = 1'b0;
         d_brcond   = 2'b00;
         d_jump     = 1'b0;
         d_halt     = 1'b1;
         d_illegal  = 1'b0;
      end
`endif
   end

   // Output registers; reset forces NOP regardless of opcode
   always_ff @(posedge clk) begin
      if (reset) begin
         R15      <= 1'b0;
         ALUSrc   <= 1'b0;
         MemToReg <= 1'b0;
         RegWrite <= 1'b0;
         MemRead  <= 1'b0;
         MemWrite <= 1'b0;
         Branch   <= 1'b0;
         ALUOP    <= '0;
         ByteOp   <= 1'b0;
         BrCond   <= '0;
         Jump     <= 1'b0;
         Halt     <= 1'b0;
         Illegal  <= 1'b0;
      end else begin
         R15      <= d_r15;
         ALUSrc   <= d_alusrc;
         MemToReg <= d_memtoreg;
         RegWrite <= d_regwrite;
         MemRead  <= d_memread;
         MemWrite <= d_memwrite;
         Branch   <= d_branch;
         ALUOP    <= d_aluop;
         ByteOp   <= d_byteop;
         BrCond   <= d_brcond;
         Jump     <= d_jump;
         Halt     <= d_halt;
         Illegal  <= d_illegal;
      end
   end

endmodule

// File: tb/tb_control.sv
// Self-checking bench for the control decoder: directed scenarios plus
// randomized opcodes/resets compared against a table-driven reference model.
// Honours CONTROL_HALT_LATCH_EN when defined for the build.
module tb_control;

   logic       clk;
   logic       reset;
   logic [3:0] opcode;
   logic       R15, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch;
   logic [1:0] ALUOP;
   logic       ByteOp;
   logic [1:0] BrCond;
   logic       Jump, Halt, Illegal;

   int errors = 0;
   int checks = 0;

   // Model state: expected packed output vector and halted flag
   logic [14:0] tbl [16];
   logic [14:0] exp_v;
   bit          m_halted;
   logic [14:0] outv;

   localparam logic [14:0] HALTV = 15'h0002;

   control dut (
      .clk(clk), .reset(reset), .opcode(opcode),
      .R15(R15), .ALUSrc(ALUSrc), .MemToReg(MemToReg), .RegWrite(RegWrite),
      .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .ALUOP(ALUOP),
      .ByteOp(ByteOp), .BrCond(BrCond), .Jump(Jump), .Halt(Halt), .Illegal(Illegal)
   );

   // Bit order: R15 ALUSrc MemToReg RegWrite MemRead MemWrite Branch ALUOP[2] ByteOp BrCond[2] Jump Halt Illegal
   assign outv = {R15, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch,
                  ALUOP, ByteOp, BrCond, Jump, Halt, Illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [14:0] mk(input bit r15, input bit src, input bit m2r,
                                      input bit rw, input bit mr, input bit mw,
                                      input bit br, input logic [1:0] aop,
                                      input bit bo, input logic [1:0] bc,
                                      input bit j, input bit h, input bit il);
      return {r15, src, m2r, rw, mr, mw, br, aop, bo, bc, j, h, il};
   endfunction

   task automatic init_model();
      for (int i = 0; i < 16; i++) tbl[i] = mk(0,0,0,0,0,0,0,2'b00,0,2'b00,0,0,1);
      tbl[4'b1111] = mk(0,0,0,1,0,0,0,2'b10,0,2'b00,0,0,0);
      tbl[4'b1000] = mk(0,1,1,1,1,0,0,2'b00,1,2'b00,0,0,0);
      tbl[4'b1001] = mk(0,1,0,0,0,1,0,2'b00,1,2'b00,0,0,0);
      tbl[4'b1010] = mk(0,1,1,1,1,0,0,2'b00,0,2'b00,0,0,0);
      tbl[4'b1011] = mk(0,1,0,0,0,1,0,2'b00,0,2'b00,0,0,0);
      tbl[4'b1100] = mk(0,1,0,1,0,0,0,2'b00,0,2'b00,0,0,0);
      tbl[4'b1101] = mk(0,1,0,1,0,0,0,2'b11,0,2'b00,0,0,0);
      tbl[4'b0101] = mk(1,0,0,0,0,0,1,2'b01,0,2'b01,0,0,0);
      tbl[4'b0100] = mk(1,0,0,0,0,0,1,2'b01,0,2'b10,0,0,0);
      tbl[4'b0110] = mk(1,0,0,0,0,0,1,2'b01,0,2'b00,0,0,0);
      tbl[4'b0001] = mk(0,0,0,0,0,0,0,2'b00,0,2'b00,1,0,0);
      tbl[4'b0000] = mk(0,0,0,0,0,0,0,2'b00,0,2'b00,0,1,0);
      m_halted = 0;
      exp_v = '0;
   endtask

   // Apply one opcode for one edge, advance the model, settle 1 time unit past the edge
   task automatic step(input logic [3:0] op, input logic rst);
      opcode = op;
      reset  = rst;
      @(posedge clk);
      if (rst) begin
         exp_v    = '0;
         m_halted = 0;
      end else if (m_halted) begin
         exp_v = HALTV;
      end else begin
         exp_v = tbl[op];
`ifdef CONTROL_HALT_LATCH_EN
         if (op == 4'b0000) m_halted = 1;
`endif
      end
      #1;
   endtask

   task automatic test_reset();
      step(4'b1111, 1'b1);
      checks++;
      if (outv !== 15'h0) begin
         errors++;
         $display("FAIL reset_all_zero: got %b want %b", outv, 15'h0);
      end
      step(4'b1111, 1'b0);
      checks++;
      if (RegWrite !== 1'b1 || ALUOP !== 2'b10 || outv !== exp_v) begin
         errors++;
         $display("FAIL reset_release_atype: got %b want %b", outv, exp_v);
      end
   endtask

   task automatic test_sweep();
      logic [3:0] ops [12];
      ops = '{4'b1111, 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100,
              4'b1101, 4'b0101, 4'b0100, 4'b0110, 4'b0001, 4'b0000};
      step(4'b1111, 1'b1);
      foreach (ops[i]) begin
         step(ops[i], 1'b0);
         checks++;
         if (outv !== exp_v) begin
            errors++;
            $display("FAIL sweep_op_%b: got %b want %b", ops[i], outv, exp_v);
         end
         if (ops[i] == 4'b1010) begin
            checks++;
            if ({ALUSrc, MemToReg, RegWrite, MemRead, ALUOP} !== 6'b111100) begin
               errors++;
               $display("FAIL sweep_lw_fields: got %b want 111100",
                        {ALUSrc, MemToReg, RegWrite, MemRead, ALUOP});
            end
         end
      end
   endtask

   task automatic test_branches();
      logic [3:0] ops [3];
      logic [1:0] cond [3];
      ops  = '{4'b0101, 4'b0100, 4'b0110};
      cond = '{2'b01, 2'b10, 2'b00};
      step(4'b1111, 1'b1);
      foreach (ops[i]) begin
         step(ops[i], 1'b0);
         checks++;
         if (R15 !== 1'b1 || Branch !== 1'b1 || ALUOP !== 2'b01 || BrCond !== cond[i] ||
             RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
            errors++;
            $display("FAIL branch_%b: got %b brcond %b want brcond %b", ops[i], outv, BrCond, cond[i]);
         end
      end
   endtask

   task automatic test_illegal();
      logic [3:0] ops [4];
      ops = '{4'b0010, 4'b0011, 4'b0111, 4'b1110};
      step(4'b1111, 1'b1);
      foreach (ops[i]) begin
         step(ops[i], 1'b0);
         checks++;
         if (outv !== 15'h0001) begin
            errors++;
            $display("FAIL illegal_%b: got %b want %b", ops[i], outv, 15'h0001);
         end
      end
      step(4'b1011, 1'b0);
      checks++;
      if (Illegal !== 1'b0 || MemWrite !== 1'b1 || ALUSrc !== 1'b1 || outv !== exp_v) begin
         errors++;
         $display("FAIL illegal_then_sw: got %b want %b", outv, exp_v);
      end
   endtask

   task automatic test_reset_midstream();
      step(4'b1111, 1'b0);
      step(4'b1001, 1'b1);
      checks++;
      if (MemWrite !== 1'b0 || outv !== 15'h0) begin
         errors++;
         $display("FAIL midreset_sb: got %b want %b", outv, 15'h0);
      end
      step(4'b1001, 1'b0);
      checks++;
      if (MemWrite !== 1'b1 || ByteOp !== 1'b1) begin
         errors++;
         $display("FAIL midreset_release_sb: got memwrite %b byteop %b want 1 1", MemWrite, ByteOp);
      end
   endtask

   task automatic test_halt();
      step(4'b1111, 1'b1);
      step(4'b0000, 1'b0);
      checks++;
      if (outv !== HALTV) begin
         errors++;
         $display("FAIL halt_first: got %b want %b", outv, HALTV);
      end
      step(4'b1111, 1'b0);
      checks++;
`ifdef CONTROL_HALT_LATCH_EN
      if (Halt !== 1'b1 || RegWrite !== 1'b0 || outv !== HALTV) begin
         errors++;
         $display("FAIL halt_latched: got %b want %b", outv, HALTV);
      end
`else
      if (Halt !== 1'b0 || RegWrite !== 1'b1) begin
         errors++;
         $display("FAIL halt_released: got halt %b regwrite %b want 0 1", Halt, RegWrite);
      end
`endif
      for (int i = 0; i < 4; i++) begin
         step(4'($urandom_range(0, 15)), 1'b0);
         checks++;
         if (outv !== exp_v) begin
            errors++;
            $display("FAIL halt_follow_%0d: got %b want %b", i, outv, exp_v);
         end
      end
      step(4'b1111, 1'b1);
      step(4'b1111, 1'b0);
      checks++;
      if (RegWrite !== 1'b1 || Halt !== 1'b0) begin
         errors++;
         $display("FAIL halt_cleared_by_reset: got %b want %b", outv, exp_v);
      end
   endtask

   task automatic test_random();
      logic [3:0] op;
      logic       rst;
      step(4'b1111, 1'b1);
      for (int i = 0; i < 300; i++) begin
         op  = 4'($urandom_range(0, 15));
         rst = ($urandom_range(0, 15) == 0);
         step(op, rst);
         checks++;
         if (outv !== exp_v) begin
            errors++;
            $display("FAIL random_%0d op %b rst %b: got %b want %b", i, op, rst, outv, exp_v);
         end
         checks++;
         if ((MemRead && MemWrite) || (MemToReg && !RegWrite) ||
             ($countones({Branch, Jump, Halt, Illegal}) > 1)) begin
            errors++;
            $display("FAIL invariant_%0d: got %b want no conflicting strobes", i, outv);
         end
      end
   endtask

   initial begin
      reset  = 1'b1;
      opcode = 4'b1111;
      init_model();
      test_reset();
      test_sweep();
      test_branches();
      test_illegal();
      test_reset_midstream();
      test_halt();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
